// File: rtl/iob_sync_asym_fifo.sv
// iob_sync_asym_fifo: single-clock FIFO with independent write/read widths over a MIN_W-unit RAM.
// Define IOB_ASYM_FIFO_ERR_EN to add sticky overflow/underflow flags (w_ovf, r_unf, err_clr).
module iob_sync_asym_fifo #(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                w_en,
    input  logic [W_DATA_W-1:0] w_data,
    output logic                w_full,
    input  logic                r_en,
    output logic [R_DATA_W-1:0] r_data,
    output logic                r_empty,
    output logic [ADDR_W:0]     level
`ifdef IOB_ASYM_FIFO_ERR_EN
    ,
    input  logic                err_clr,
    output logic                w_ovf,
    output logic                r_unf
`endif
);
    localparam int MIN_W   = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
    localparam int RATIO_W = W_DATA_W / MIN_W;
    localparam int RATIO_R = R_DATA_W / MIN_W;
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   LVL_W   = (ADDR_W + 1)'(RATIO_W);
    localparam logic [ADDR_W:0]   LVL_R   = (ADDR_W + 1)'(RATIO_R);
    localparam logic [ADDR_W:0]   FULL_TH = (ADDR_W + 1)'(DEPTH - RATIO_W);
    localparam logic [ADDR_W-1:0] PTR_W   = ADDR_W'(RATIO_W);
    localparam logic [ADDR_W-1:0] PTR_R   = ADDR_W'(RATIO_R);
    logic [MIN_W-1:0]    mem [DEPTH];
    logic [ADDR_W-1:0]   w_ptr, r_ptr;
    logic                w_acc, r_acc;
    logic [ADDR_W:0]     level_nxt;
    logic [R_DATA_W-1:0] rd_word;
    assign w_acc = w_en & ~w_full;
    assign r_acc = r_en & ~r_empty;
    // level never exceeds DEPTH since a write is only accepted with RATIO_W units free
    always_comb begin
        level_nxt = level + (w_acc ? LVL_W : '0) - (r_acc ? LVL_R : '0);
    end
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < RATIO_R; i++)
            rd_word[i*MIN_W +: MIN_W] = mem[r_ptr + ADDR_W'(i)];
    end
    // Storage is deliberately left unreset; lower address holds the LSB unit
    always_ff @(posedge clk) begin
        if (w_acc)
            for (int i = 0; i < RATIO_W; i++)
                mem[w_ptr + ADDR_W'(i)] <= w_data[i*MIN_W +: MIN_W];
    end
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            level   <= '0;
            w_full  <= 1'b0;
            r_empty <= 1'b1;
            r_data  <= '0;
        end else begin
            w_ptr   <= w_acc ? w_ptr + PTR_W : w_ptr;
            r_ptr   <= r_acc ? r_ptr + PTR_R : r_ptr;
            level   <= level_nxt;
            w_full  <= level_nxt > FULL_TH;
            r_empty <= level_nxt < LVL_R;
            r_data  <= r_acc ? rd_word : r_data;
        end
    end
`ifdef IOB_ASYM_FIFO_ERR_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            w_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            w_ovf <= err_clr ? 1'b0 : (w_ovf | (w_en & w_full));
            r_unf <= err_clr ? 1'b0 : (r_unf | (r_en & r_empty));
        end
    end
`endif
endmodule

// File: tb/tb_iob_sync_asym_fifo.sv
// tb_iob_sync_asym_fifo: queue-model bench for a 32->8 and an 8->32 instance of iob_sync_asym_fifo.
module tb_iob_sync_asym_fifo;
    logic        clk = 1'b0, arst_n = 1'b0, err_clr = 1'b0;
    logic        a_wen, a_ren, a_full, a_empty;
    logic [31:0] a_wdata;
    logic [7:0]  a_rdata;
    logic [4:0]  a_level;
    logic        b_wen, b_ren, b_full, b_empty;
    logic [7:0]  b_wdata;
    logic [31:0] b_rdata;
    logic [4:0]  b_level;
    int          checks = 0, errors = 0;
    bit          chk_en = 1'b0;
    logic [7:0]  qa[$], qb[$];
    logic [7:0]  ea_rd;
    logic [31:0] eb_rd, wd;
    bit          ea_ovf, ea_unf, wa, ra, wb, rb;
`ifdef IOB_ASYM_FIFO_ERR_EN
    logic a_ovf, a_unf, b_ovf, b_unf;
`endif

    iob_sync_asym_fifo #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) dut_a (
        .clk(clk), .arst_n(arst_n), .w_en(a_wen), .w_data(a_wdata), .w_full(a_full),
        .r_en(a_ren), .r_data(a_rdata), .r_empty(a_empty), .level(a_level)
`ifdef IOB_ASYM_FIFO_ERR_EN
        , .err_clr(err_clr), .w_ovf(a_ovf), .r_unf(a_unf)
`endif
    );
    iob_sync_asym_fifo #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) dut_b (
        .clk(clk), .arst_n(arst_n), .w_en(b_wen), .w_data(b_wdata), .w_full(b_full),
        .r_en(b_ren), .r_data(b_rdata), .r_empty(b_empty), .level(b_level)
`ifdef IOB_ASYM_FIFO_ERR_EN
        , .err_clr(err_clr), .w_ovf(b_ovf), .r_unf(b_unf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
        end
    endtask

    // Byte-queue model: capacity 16 bytes, accept rules from free/stored byte counts
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            qa.delete(); qb.delete();
            ea_rd = '0; eb_rd = '0; ea_ovf = 0; ea_unf = 0;
        end else begin
            wa = a_wen && (16 - qa.size()) >= 4;
            ra = a_ren && qa.size() >= 1;
            wb = b_wen && qb.size() < 16;
            rb = b_ren && qb.size() >= 4;
            ea_ovf = err_clr ? 1'b0 : (ea_ovf | (a_wen && !wa));
            ea_unf = err_clr ? 1'b0 : (ea_unf | (a_ren && !ra));
            if (ra) ea_rd = qa.pop_front();
            if (wa) for (int i = 0; i < 4; i++) qa.push_back(a_wdata[8*i +: 8]);
            if (rb) for (int i = 0; i < 4; i++) eb_rd[8*i +: 8] = qb.pop_front();
            if (wb) qb.push_back(b_wdata);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_level", a_level, qa.size());
            check("a_full", a_full, (16 - qa.size()) < 4);
            check("a_empty", a_empty, qa.size() < 1);
            check("a_rdata", a_rdata, ea_rd);
            check("b_level", b_level, qb.size());
            check("b_full", b_full, qb.size() >= 16);
            check("b_empty", b_empty, qb.size() < 4);
            check("b_rdata", b_rdata, eb_rd);
`ifdef IOB_ASYM_FIFO_ERR_EN
            check("a_ovf", a_ovf, ea_ovf);
            check("a_unf", a_unf, ea_unf);
`endif
        end
    end

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_a(int b);
        a_wen = 1'b1;
        a_wdata = {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
    endtask

    initial begin
        a_wen = 0; a_ren = 0; a_wdata = '0;
        b_wen = 0; b_ren = 0; b_wdata = '0;
        cyc(2);
        chk_en = 1'b1;
        arst_n = 1'b1;
        cyc(1);
        // read on empty
        a_ren = 1; b_ren = 1;
        cyc(1);
        a_ren = 0; b_ren = 0;
        check("empty_read_rdata", a_rdata, 8'h00);
        check("empty_read_level", a_level, 5'd0);
        check("empty_read_b_rdata", b_rdata, 32'h0);
`ifdef IOB_ASYM_FIFO_ERR_EN
        check("unf_set", a_unf, 1'b1);
        err_clr = 1; cyc(1); err_clr = 0;
        check("unf_clr", a_unf, 1'b0);
`endif
        // fill 32->8 to full, then one rejected write
        for (int w = 0; w < 4; w++) begin
            wr_a(8'h20 + 4 * w);
            cyc(1);
        end
        a_wen = 0;
        check("fill_level", a_level, 5'd16);
        check("fill_full", a_full, 1'b1);
        a_wen = 1; a_wdata = 32'hDEADBEEF;
        cyc(1);
        a_wen = 0;
        check("ovf_level", a_level, 5'd16);
`ifdef IOB_ASYM_FIFO_ERR_EN
        check("ovf_set", a_ovf, 1'b1);
        err_clr = 1; cyc(1); err_clr = 0;
        check("ovf_clr", a_ovf, 1'b0);
`endif
        for (int i = 0; i < 16; i++) begin
            a_ren = 1;
            cyc(1);
            check("drain_byte", a_rdata, 8'(8'h20 + i));
        end
        a_ren = 0;
        check("drain_empty", a_empty, 1'b1);
        check("drain_level", a_level, 5'd0);
        // 8->32 packing
        for (int i = 0; i < 3; i++) begin
            b_wen = 1; b_wdata = 8'(8'h20 + i);
            cyc(1);
        end
        b_wen = 0;
        check("b_level3", b_level, 5'd3);
        check("b_empty3", b_empty, 1'b1);
        b_wen = 1; b_wdata = 8'h23;
        cyc(1);
        b_wen = 0;
        check("b_empty4", b_empty, 1'b0);
        b_ren = 1;
        cyc(1);
        b_ren = 0;
        check("b_word", b_rdata, 32'h23222120);
        // simultaneous read/write up to the full clamp, across pointer wrap
        wr_a(8'h30); cyc(1);
        wr_a(8'h34); cyc(1);
        check("rw_level8", a_level, 5'd8);
        a_ren = 1;
        for (int k = 0; k < 4; k++) begin
            wr_a(8'h38 + 4 * k);
            cyc(1);
        end
        a_ren = 0;
        check("rw_level12", a_level, 5'd12);
        wr_a(8'h50); cyc(1);
        a_wen = 0;
        check("rw_level16", a_level, 5'd16);
        a_ren = 1;
        cyc(1);
        check("wrap_first", a_rdata, 8'h34);
        cyc(15);
        a_ren = 0;
        check("wrap_last", a_rdata, 8'h53);
        // async reset mid-stream at level 8
        for (int w = 0; w < 3; w++) begin
            wr_a(8'h60 + 4 * w);
            cyc(1);
        end
        a_wen = 0; a_ren = 1;
        cyc(4);
        a_ren = 0;
        check("pre_rst_level", a_level, 5'd8);
        check("pre_rst_rdata", a_rdata, 8'h63);
        #2 arst_n = 0;
        #1;
        check("rst_level", a_level, 5'd0);
        check("rst_empty", a_empty, 1'b1);
        check("rst_full", a_full, 1'b0);
        check("rst_rdata", a_rdata, 8'h00);
        cyc(1);
        arst_n = 1;
        wr_a(8'h70); cyc(1);
        a_wen = 0; a_ren = 1;
        cyc(1);
        check("fresh_first", a_rdata, 8'h70);
        cyc(3);
        a_ren = 0;
        check("fresh_last", a_rdata, 8'h73);
        check("fresh_level", a_level, 5'd0);
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
